// File: rtl/io_dec_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : io_dec_tx                                                    |
// | Description : Captures 64-bit CPU output values on the rising edge of an   |
// |               output strobe and queues them in a small FIFO. Each value is |
// |               converted to decimal with double-dabble and streamed out as  |
// |               ASCII digits (no leading zeros) followed by a newline.       |
// | Ports       : clk, rst          - clock, synchronous active-high reset     |
// |               io_write, io_data - CPU strobe and 64-bit value              |
// |               out_valid/ready   - byte stream handshake, out_data = byte   |
// |               overflow          - sticky, a capture was dropped (FIFO full)|
// |               busy              - FIFO non-empty or conversion in progress |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module io_dec_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        io_write,
    input  logic [63:0] io_data,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        overflow,
    output logic        busy
);

    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_DIGITS = 20;

    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [6:0]         c_STEPS = 7'd64;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_CONV = 2'd1;
    localparam logic [1:0] c_EMIT = 2'd2;
    localparam logic [1:0] c_NL   = 2'd3;

    // ------------------------------------------------------------------
    // Capture and FIFO
    // ------------------------------------------------------------------
    logic                r_prev_write;
    logic [63:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_overflow;

    logic                w_capture;
    logic                w_push;
    logic                w_pop;

    assign w_capture = io_write && !r_prev_write && !rst;
    // Room is judged on occupancy before this cycle's pop, so a push that
    // coincides with a pop on a full FIFO is dropped.
    assign w_push    = w_capture && (r_count < c_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_write <= 1'b0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_prev_write <= io_write;
            if (w_capture && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= io_data;
        end
    end

    // ------------------------------------------------------------------
    // Conversion datapath
    // ------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [63:0]         r_shift;
    logic [79:0]         r_bcd;
    logic [6:0]          r_bit_cnt;
    logic [4:0]          r_index;

    logic [79:0]         w_bcd_adj;
    logic [4:0]          w_msd;
    logic [3:0]          w_digit;
    logic                w_hs;

    genvar gi;
    generate
        for (gi = 0; gi < c_DIGITS; gi++) begin : g_dabble
            assign w_bcd_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5)
                                        ? r_bcd[gi*4 +: 4] + 4'd3
                                        : r_bcd[gi*4 +: 4];
        end
    endgenerate

    // Most significant nonzero digit; falls back to digit 0 for a zero value.
    always_comb begin
        w_msd = '0;
        for (int i = 0; i < c_DIGITS; i++) begin
            if (r_bcd[i*4 +: 4] != 4'd0) begin
                w_msd = 5'(i);
            end
        end
    end

    assign w_digit = r_bcd[{r_index, 2'b00} +: 4];
    assign w_hs    = out_valid && out_ready;

    // After the 64th dabble step CONV spends one more cycle picking the
    // leading digit from the settled BCD register, which keeps the digit
    // search off the add-3/shift path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_bcd     <= '0;
            r_bit_cnt <= '0;
            r_index   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                c_IDLE: begin
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_bcd     <= '0;
                        r_bit_cnt <= '0;
                    end
                end
                c_CONV: begin
                    if (r_bit_cnt != c_STEPS) begin
                        r_bcd     <= {w_bcd_adj[78:0], r_shift[63]};
                        r_shift   <= {r_shift[62:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 7'd1;
                    end else begin
                        r_index <= w_msd;
                    end
                end
                c_EMIT: begin
                    if (w_hs && (r_index != 5'd0)) begin
                        r_index <= r_index - 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        out_valid    = 1'b0;
        out_data     = 8'h00;
        case (r_state)
            c_IDLE: begin
                if (r_count != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = c_CONV;
                end
            end
            c_CONV: begin
                if (r_bit_cnt == c_STEPS) begin
                    w_state_next = c_EMIT;
                end
            end
            c_EMIT: begin
                out_valid = 1'b1;
                out_data  = 8'h30 + {4'h0, w_digit};
                if (w_hs && (r_index == 5'd0)) begin
                    w_state_next = c_NL;
                end
            end
            c_NL: begin
                out_valid = 1'b1;
                out_data  = 8'h0A;
                if (w_hs) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    assign overflow = r_overflow;
    assign busy     = (r_count != '0) || (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_io_dec_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_io_dec_tx                                                 |
// | Description : Directed self-checking bench for io_dec_tx. Accepted bytes   |
// |               are collected into a queue and compared with hand-computed  |
// |               decimal strings; latency, stalls, overflow and reset are    |
// |               checked against fixed expected values.                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_io_dec_tx;

    logic        clk;
    logic        rst;
    logic        io_write;
    logic [63:0] io_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;
    logic        overflow;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] rx_q[$];

    io_dec_tx #(
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .io_write  (io_write),
        .io_data   (io_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge, so at the falling edge
    // they already hold what the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            rx_q.push_back(out_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse(input logic [63:0] value, input int width);
        io_data  = value;
        io_write = 1'b1;
        repeat (width) tick();
        io_write = 1'b0;
        repeat (width) tick();
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 300) begin
            tick();
            n++;
        end
        check(tag, out_valid, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 3000) begin
            tick();
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    task automatic expect_str(input string tag, input string s);
        int len;
        check($sformatf("%s_len", tag), rx_q.size(), s.len());
        len = (rx_q.size() < s.len()) ? rx_q.size() : s.len();
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s[%0d]", tag, i), rx_q[i], s[i]);
        end
        rx_q.delete();
    endtask

    initial begin
        int  lat;
        logic hold_ok;

        rst       = 1'b1;
        io_write  = 1'b0;
        io_data   = '0;
        out_ready = 1'b1;
        do_reset();

        // Reset state
        check("rst_valid", out_valid, 1'b0);
        check("rst_data",  out_data,  8'h00);
        check("rst_busy",  busy,      1'b0);
        check("rst_ovf",   overflow,  1'b0);

        // 42 with latency measurement
        io_data  = 64'd42;
        io_write = 1'b1;
        tick();
        io_write = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        check("latency", lat, 66);
        wait_idle("idle_42");
        expect_str("v42", "42\n");

        // Boundary values
        pulse(64'd0, 1);
        wait_idle("idle_0");
        expect_str("v0", "0\n");
        pulse(64'hFFFF_FFFF_FFFF_FFFF, 1);
        wait_idle("idle_max");
        expect_str("vmax", "18446744073709551615\n");

        // Back-pressure: byte held for 10 stalled cycles
        out_ready = 1'b0;
        pulse(64'd7, 1);
        wait_valid("v7_valid");
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!out_valid || out_data != 8'h37) hold_ok = 1'b0;
            tick();
        end
        check("stall_hold", hold_ok, 1'b1);
        check("stall_norx", rx_q.size(), 0);
        out_ready = 1'b1;
        wait_idle("idle_7");
        expect_str("v7", "7\n");

        // Overflow: 4 queued + 1 in conversion, 6th dropped
        out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            pulse(64'(v), 2);
        end
        check("ovf_set", overflow, 1'b1);
        repeat (5) tick();
        check("ovf_sticky", overflow, 1'b1);
        out_ready = 1'b1;
        wait_idle("idle_ovf");
        expect_str("vovf", "1\n2\n3\n4\n5\n");
        check("ovf_after", overflow, 1'b1);

        // Reset during emission with values queued
        do_reset();
        out_ready = 1'b0;
        pulse(64'd12345, 1);
        pulse(64'd11, 1);
        pulse(64'd22, 1);
        pulse(64'd33, 1);
        wait_valid("v12345_valid");
        out_ready = 1'b1;
        tick();
        rst      = 1'b1;
        io_write = 1'b1;
        io_data  = 64'd9;
        tick();
        check("mrst_valid", out_valid, 1'b0);
        check("mrst_data",  out_data,  8'h00);
        check("mrst_busy",  busy,      1'b0);
        check("mrst_ovf",   overflow,  1'b0);
        rst = 1'b0;
        repeat (5) tick();
        io_write = 1'b0;
        wait_idle("idle_mrst");
        expect_str("vmrst", "19\n");
        check("mrst_ovf2", overflow, 1'b0);

        // Held strobe counts once; a second edge during EMIT is queued
        out_ready = 1'b0;
        io_data   = 64'd55;
        io_write  = 1'b1;
        repeat (20) tick();
        io_write = 1'b0;
        wait_valid("v55_valid");
        check("v55_first", out_data, 8'h35);
        pulse(64'd66, 1);
        out_ready = 1'b1;
        wait_idle("idle_55");
        expect_str("v55", "55\n66\n");
        check("v55_ovf", overflow, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
